seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 206 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arithmetic/shift ops and
// multi-cycle unsigned shift-add multiply and restoring divide/remainder.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_n        - asynchronous active-low reset
//   start        - request, accepted only while busy=0
//   ctrl[3:0]    - operation code, sampled at accept
//   in1, in2     - signed operands, sampled at accept
//   shamt        - shift amount, sampled at accept
//   busy         - a MUL/DIV/REM operation is in progress
//   done         - one-cycle pulse, results valid
//   out          - primary result (registered)
//   out_hi       - MUL high half or DIV/REM remainder, else 0
//   zero         - out==0, registered with out
//   div_by_zero  - divisor was 0 on this completion, registered with out
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_REM  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  // The counter reaching WIDTH marks the completion edge after WIDTH iterations.
  localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [SHW:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_rem_q, is_rem_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     out_hi_q, out_hi_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic [WIDTH-1:0]     new_rem;
  logic                 q_bit;

  // Single-cycle result, straight from the live operands at accept time.
  always_comb begin
    alu_res = '0;
    case (ctrl)
      OP_AND:          alu_res = in1 & in2;
      OP_OR:           alu_res = in1 | in2;
      OP_NOR:          alu_res = ~(in1 | in2);
      OP_ADD, OP_ADDI: alu_res = in1 + in2;
      OP_SUB:          alu_res = in1 - in2;
      OP_SLT:          alu_res[0] = ($signed(in1) < $signed(in2));
      OP_EQ:           alu_res[0] = (in1 != in2);
      OP_SLL:          alu_res = in2 << shamt;
      OP_SRL:          alu_res = $unsigned($signed(in2) >>> shamt);
      default:         alu_res = '0;
    endcase
  end

  // Iteration datapath. acc_q holds {high, low}: for MUL the running partial
  // product over the shifting multiplier, for DIV the remainder over the
  // shifting dividend/quotient. With a zero divisor every compare succeeds,
  // so the quotient fills with ones and the remainder ends up equal to in1,
  // which is exactly the required divide-by-zero result.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, opb_q});
    rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    new_rem   = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
  end

  // Next-state and result logic; results only move on a completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_rem_d = is_rem_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ctrl)
            OP_MUL: begin
              state_d = S_MUL;
              cnt_d   = '0;
              acc_d   = {{WIDTH{1'b0}}, in1};
              opb_d   = in2;
            end
            OP_DIV, OP_REM: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, in1};
              opb_d    = in2;
              is_rem_d = (ctrl == OP_REM);
            end
            default: begin
              out_d    = alu_res;
              out_hi_d = '0;
              zero_d   = (alu_res == '0);
              dbz_d    = 1'b0;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          out_d    = acc_q[WIDTH-1:0];
          out_hi_d = acc_q[2*WIDTH-1:WIDTH];
          zero_d   = (acc_q[WIDTH-1:0] == '0);
          dbz_d    = 1'b0;
          done_d   = 1'b1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          out_d    = is_rem_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
          out_hi_d = acc_q[2*WIDTH-1:WIDTH];
          zero_d   = is_rem_q ? (acc_q[2*WIDTH-1:WIDTH] == '0) : (acc_q[WIDTH-1:0] == '0);
          dbz_d    = (opb_q == '0);
          done_d   = 1'b1;
        end else begin
          acc_d = {new_rem, acc_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_rem_q <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_rem_q <= is_rem_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign out         = out_q;
  assign out_hi      = out_hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Stimulus pushes the
// hand-computed expected completion into a queue; a monitor pops and
// compares whenever done is seen.
module tb_seq_alu;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_REM  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [31:0] out_hi;
  logic        zero;
  logic        div_by_zero;

  typedef struct {
    string       name;
    logic [31:0] e_out;
    logic [31:0] e_hi;
    logic        e_zero;
    logic        e_dbz;
    int          acc;
    int          due;
    bit          multi;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ctrl        (ctrl),
    .in1         (in1),
    .in2         (in2),
    .shamt       (shamt),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .out_hi      (out_hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock and an edge counter used to time completions.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, report it if wrong.
  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Present one request at a negedge and push its expected completion.
  task automatic applyStimulus(input string nm, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input logic [31:0] eo, input logic [31:0] eh,
                               input logic ez, input logic ed, input bit multi);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    ctrl  = c;
    in1   = a;
    in2   = b;
    shamt = sh;
    e.name   = nm;
    e.e_out  = eo;
    e.e_hi   = eh;
    e.e_zero = ez;
    e.e_dbz  = ed;
    e.acc    = cyc + 1;
    e.due    = cyc + 1 + (multi ? 33 : 0);
    e.multi  = multi;
    sb.push_back(e);
  endtask

  task automatic endStart();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the scoreboard to drain, bounded.
  task automatic waitIdle(input int budget);
    int i;
    i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: busy while a multi-cycle op is pending, full result check on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].multi && cyc >= sb[0].acc && cyc < sb[0].due)
        checkOutput({sb[0].name, "_busy"}, 64'(busy), 64'd1);
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
          checkOutput({e.name, "_out"}, 64'(out), 64'(e.e_out));
          checkOutput({e.name, "_out_hi"}, 64'(out_hi), 64'(e.e_hi));
          checkOutput({e.name, "_zero"}, 64'(zero), 64'(e.e_zero));
          checkOutput({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.e_dbz));
          checkOutput({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        checkOutput({e.name, "_done"}, 64'(done), 64'd1);
      end
    end
  end

  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = 4'd0;
    in1   = '0;
    in2   = '0;
    shamt = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out", 64'(out), 64'd0);
    checkOutput("rst_out_hi", 64'(out_hi), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd1);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Single-cycle ops, issued back-to-back.
    applyStimulus("add",  OP_ADD,  32'd7, 32'hFFFF_FFFD, 5'd0, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub",  OP_SUB,  32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("srl",  OP_SRL,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("and",  OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("or",   OP_OR,   32'hF0F0_0000, 32'h0000_1234, 5'd0, 32'hF0F0_1234, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("nor",  OP_NOR,  32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("slt1", OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("slt0", OP_SLT,  32'd5, 32'hFFFF_FFFE, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("eq_same", OP_EQ, 32'd3, 32'd3, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("eq_diff", OP_EQ, 32'd3, 32'd4, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sll",  OP_SLL,  32'd0, 32'd1, 5'd31, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("addi_wrap", OP_ADDI, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("undef", 4'b0101, 32'h1234_5678, 32'h1, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    endStart();
    waitIdle(10);

    // Multiply.
    applyStimulus("mul_ff_2", OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b1);
    endStart();
    waitIdle(50);
    applyStimulus("mul_x16", OP_MUL, 32'h1234_5678, 32'h10, 5'd0, 32'h2345_6780, 32'h1, 1'b0, 1'b0, 1'b1);
    endStart();
    waitIdle(50);

    // DIV with ignored requests and changing inputs while busy, then REM by
    // zero accepted in the very cycle done is high.
    applyStimulus("div_100_7", OP_DIV, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
    repeat (33) begin
      @(negedge clk);
      start = 1'b1;
      ctrl  = OP_ADD;
      in1   = $urandom;
      in2   = $urandom;
    end
    applyStimulus("rem_100_0", OP_REM, 32'd100, 32'd0, 5'd0, 32'd100, 32'd100, 1'b0, 1'b1, 1'b1);
    endStart();
    waitIdle(50);

    applyStimulus("div_7_0", OP_DIV, 32'd7, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b1, 1'b1);
    endStart();
    waitIdle(50);
    applyStimulus("div_5_7", OP_DIV, 32'd5, 32'd7, 5'd0, 32'd0, 32'd5, 1'b1, 1'b0, 1'b1);
    endStart();
    waitIdle(50);
    applyStimulus("rem_big_3", OP_REM, 32'h8000_0000, 32'd3, 5'd0, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
    endStart();
    waitIdle(50);

    // Abort a DIV with reset; the ADD pulse while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    ctrl  = OP_DIV;
    in1   = 32'd1000;
    in2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    ctrl  = OP_ADD;
    in1   = 32'd7;
    in2   = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", 64'(busy), 64'd1);
    checkOutput("abort_out_held", 64'(out), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_out", 64'(out), 64'd0);
    checkOutput("abort_out_hi", 64'(out_hi), 64'd0);
    checkOutput("abort_zero", 64'(zero), 64'd1);
    checkOutput("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checkOutput("abort_no_done", 64'(n_done), 64'd0);
    checkOutput("abort_idle_after", 64'(busy), 64'd0);

    // Normal operation resumes after reset.
    applyStimulus("add_resume", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    endStart();
    waitIdle(10);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
